// File: rtl/i2s_tx_sequencer.sv
// -----------------------------------------------------------------------------
// i2s_tx_sequencer
//
// Transmit-side I2S frame engine. Upstream hands over stereo sample pairs on a
// valid/ready handshake into a one-entry buffer. The block divides the system
// clock into the bit clock, drives word select, and shifts each pair out
// MSB-first in standard I2S framing (ws leads the data MSB by one bclk).
// A frame launches at the bit boundary entering slot 1. If the buffer is empty
// at that moment, a silent frame is sent and an underrun pulse is raised.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           run request; IDLE->RUN on any edge, RUN->IDLE only at frame end
//   s_valid      upstream pair valid
//   s_ready      buffer empty, pair can be accepted
//   s_left       left-channel sample  (WIDTH bits)
//   s_right      right-channel sample (WIDTH bits)
//   bclk         bit clock (registered)
//   ws           word select, 0 = left, 1 = right (registered)
//   sd           serial data, changes with bclk falling (registered)
//   frame_start  one-clk pulse when a frame's left MSB is launched
//   underrun     one-clk pulse when a frame launches with the buffer empty
//   busy         high while running
// -----------------------------------------------------------------------------
module i2s_tx_sequencer #(
    parameter int WIDTH       = 16,
    parameter int CLK_PER_BIT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_left,
    input  logic [WIDTH-1:0] s_right,
    output logic             bclk,
    output logic             ws,
    output logic             sd,
    output logic             frame_start,
    output logic             underrun,
    output logic             busy
);

    localparam int SLOT_W = $clog2(2 * WIDTH);
    localparam int DIV_W  = $clog2(CLK_PER_BIT);
    // Shift register holds everything after the left MSB, which goes straight to sd at launch.
    localparam int SHR_W  = 2 * WIDTH - 1;

    localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_PER_BIT - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_PER_BIT / 2);
    localparam logic [DIV_W-1:0]  DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(2 * WIDTH - 1);
    localparam logic [SLOT_W-1:0] SLOT_WS   = SLOT_W'(WIDTH);
    localparam logic [SLOT_W-1:0] SLOT_ZERO = {SLOT_W{1'b0}};
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DIV_W-1:0]   div_cnt_r;
    logic [DIV_W-1:0]   div_nxt_s;
    logic [SLOT_W-1:0]  slot_r;
    logic [SLOT_W-1:0]  slot_nxt_s;

    logic               full_r;
    logic [WIDTH-1:0]   buf_left_r;
    logic [WIDTH-1:0]   buf_right_r;
    logic [SHR_W-1:0]   shift_r;

    logic               bclk_r;
    logic               ws_r;
    logic               sd_r;
    logic               frame_start_r;
    logic               underrun_r;
    logic               busy_r;

    logic               div_last_s;
    logic               boundary_s;
    logic               frame_end_s;
    logic               launch_s;
    logic               stop_s;
    logic               accept_s;

    // Timing events derived from the current counter state.
    always_comb begin
        div_last_s  = (div_cnt_r == DIV_MAX);
        boundary_s  = (state_r == ST_RUN) && div_last_s;
        // The boundary that ends slot 0 is where a frame either launches or the run stops.
        frame_end_s = boundary_s && (slot_r == SLOT_ZERO);
        launch_s    = frame_end_s && en;
        stop_s      = frame_end_s && !en;
        accept_s    = s_valid && !full_r;
    end

    // Next-state and next-counter logic for the IDLE/RUN sequencer.
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_cnt_r;
        slot_nxt_s  = slot_r;
        case (state_r)
            ST_IDLE: begin
                div_nxt_s  = DIV_ZERO;
                slot_nxt_s = SLOT_ZERO;
                if (en) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop_s) begin
                    state_nxt_s = ST_IDLE;
                    div_nxt_s   = DIV_ZERO;
                    slot_nxt_s  = SLOT_ZERO;
                end else if (div_last_s) begin
                    div_nxt_s = DIV_ZERO;
                    if (slot_r == SLOT_MAX) begin
                        slot_nxt_s = SLOT_ZERO;
                    end else begin
                        slot_nxt_s = slot_r + SLOT_ONE;
                    end
                end else begin
                    div_nxt_s = div_cnt_r + DIV_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                div_nxt_s   = DIV_ZERO;
                slot_nxt_s  = SLOT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            div_cnt_r <= DIV_ZERO;
            slot_r    <= SLOT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            div_cnt_r <= div_nxt_s;
            slot_r    <= slot_nxt_s;
        end
    end

    // One-entry sample buffer; a launch that finds it full takes precedence, so an
    // accept can only coincide with a launch that found it empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r      <= 1'b0;
            buf_left_r  <= {WIDTH{1'b0}};
            buf_right_r <= {WIDTH{1'b0}};
        end else if (launch_s && full_r) begin
            full_r <= 1'b0;
        end else if (accept_s) begin
            full_r      <= 1'b1;
            buf_left_r  <= s_left;
            buf_right_r <= s_right;
        end else begin
            full_r <= full_r;
        end
    end

    // Serialiser: load on launch, shift one bit per boundary. The final shift of a
    // frame lands in the next frame's slot 0, which is the right-channel LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {SHR_W{1'b0}};
            sd_r    <= 1'b0;
        end else if (launch_s) begin
            if (full_r) begin
                shift_r <= {buf_left_r[WIDTH-2:0], buf_right_r};
                sd_r    <= buf_left_r[WIDTH-1];
            end else begin
                shift_r <= {SHR_W{1'b0}};
                sd_r    <= 1'b0;
            end
        end else if (boundary_s && !stop_s) begin
            shift_r <= {shift_r[SHR_W-2:0], 1'b0};
            sd_r    <= shift_r[SHR_W-1];
        end else if (state_nxt_s == ST_IDLE) begin
            sd_r <= 1'b0;
        end else begin
            sd_r <= sd_r;
        end
    end

    // Line outputs and status pulses, registered from the next-cycle counter values
    // so bclk/ws line up exactly with div_cnt/slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_r        <= 1'b0;
            ws_r          <= 1'b0;
            busy_r        <= 1'b0;
            frame_start_r <= 1'b0;
            underrun_r    <= 1'b0;
        end else begin
            bclk_r        <= (state_nxt_s == ST_RUN) && (div_nxt_s >= DIV_HALF);
            ws_r          <= (state_nxt_s == ST_RUN) && (slot_nxt_s >= SLOT_WS);
            busy_r        <= (state_nxt_s == ST_RUN);
            frame_start_r <= launch_s;
            underrun_r    <= launch_s && !full_r;
        end
    end

    assign s_ready     = !full_r;
    assign bclk        = bclk_r;
    assign ws          = ws_r;
    assign sd          = sd_r;
    assign frame_start = frame_start_r;
    assign underrun    = underrun_r;
    assign busy        = busy_r;

endmodule
